// File: rtl/rf_param.sv
// rf_param: parametrised register file, NUM_RD read ports, one write port.
// Write-through bypass, optional zero register, read hold, clear sweep.
module rf_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        re,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     we,
  input  logic                     clr,
  output logic                     busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic ZR = (ZERO_REG != 0);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] idx;
  logic              wr_acc;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_a;
  logic [DATA_W-1:0] wr_d;

  logic [DATA_W-1:0] mem [DEPTH];

  // a write is only real when idle and not aimed at the zero register
  assign wr_acc = we && !busy && !(ZR && (wr_addr == '0));

  // state register; reset always starts a fresh sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_nxt;
  end

  // next state: clear request enters sweep, last index exits it
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (clr) state_nxt = CLEAR;
      CLEAR:   if (idx == LAST) state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  // outputs: busy flag and the single array write port mux
  always_comb begin
    busy  = 1'b0;
    wr_en = wr_acc;
    wr_a  = wr_addr;
    wr_d  = wr_data;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
      end
      CLEAR: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        wr_a  = idx;
        wr_d  = '0;
      end
      default: begin
        busy  = 1'b1;
        wr_en = 1'b0;
      end
    endcase
  end

  // sweep index advances only while clearing, wraps to 0 on exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    idx <= '0;
    else if (busy) idx <= idx + 1'b1;
    else           idx <= '0;
  end

  // storage array, zeroed by the sweep rather than by reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_a] <= wr_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] hold;

    assign ra = rd_addr[i*ADDR_W +: ADDR_W];

    // live read value with zero-reg, busy and bypass priority
    always_comb begin
      val = mem[ra];
      if (ZR && (ra == '0))
        val = '0;
      else if (busy)
        val = '0;
      else if (wr_acc && (wr_addr == ra))
        val = wr_data;
    end

    // hold register captures whatever was presented while enabled
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     hold <= '0;
      else if (re[i]) hold <= val;
    end

    assign rd_data[i*DATA_W +: DATA_W] = re[i] ? val : hold;
  end

endmodule

// File: tb/tb_rf_param.sv
// tb_rf_param: directed checks for rf_param.
// Two instances: zero register enabled and disabled.
module tb_rf_param;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 2;

  logic           clk;
  logic           rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR-1:0]  re;
  logic [NR*DW-1:0] rd_data;
  logic [NR*DW-1:0] rd_data0;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           we;
  logic           clr;
  logic           busy;
  logic           busy0;

  int n_chk;
  int n_pass;
  int n;

  rf_param #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .re(re), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .we(we),
    .clr(clr), .busy(busy)
  );

  rf_param #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .re(re), .rd_data(rd_data0),
    .wr_addr(wr_addr), .wr_data(wr_data), .we(we),
    .clr(clr), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busy_len(output int cnt);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) cnt++;
      else break;
    end
  endtask

  function automatic logic [15:0] p0(input logic [31:0] d);
    return d[15:0];
  endfunction

  function automatic logic [15:0] p1(input logic [31:0] d);
    return d[31:16];
  endfunction

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    rd_addr = '0;
    re      = '0;
    wr_addr = '0;
    wr_data = '0;
    we      = 1'b0;
    clr     = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_busy0", 32'(busy0), 32'd1);
    chk("rst_hold", rd_data, 32'h0);
    rst_n = 1'b1;
    busy_len(n);
    chk("rst_sweep_len", n, 16);
    chk("rst_sweep_len0", 32'(busy0), 32'd0);

    // every address reads zero after the sweep
    for (int j = 0; j < 8; j++) begin
      rd_addr = {4'(2*j+1), 4'(2*j)};
      re      = 2'b11;
      #2;
      chk($sformatf("clr_rd_%0d", j), rd_data, 32'h0);
      chk($sformatf("clr_rd0_%0d", j), rd_data0, 32'h0);
    end

    // bypass then stored value
    tick();
    re      = 2'b01;
    rd_addr = {4'd0, 4'd5};
    we      = 1'b1;
    wr_addr = 4'd5;
    wr_data = 16'hBEEF;
    @(negedge clk);
    chk("bypass", 32'(p0(rd_data)), 32'hBEEF);
    tick();
    we = 1'b0;
    @(negedge clk);
    chk("mem_read", 32'(p0(rd_data)), 32'hBEEF);

    // zero register enabled vs disabled
    tick();
    re      = 2'b11;
    rd_addr = {4'd0, 4'd0};
    we      = 1'b1;
    wr_addr = 4'd0;
    wr_data = 16'h1234;
    @(negedge clk);
    chk("zr_byp", rd_data, 32'h0);
    chk("nzr_byp", rd_data0, 32'h1234_1234);
    tick();
    we = 1'b0;
    @(negedge clk);
    chk("zr_mem", rd_data, 32'h0);
    chk("nzr_mem", rd_data0, 32'h1234_1234);

    // read hold is undisturbed by later writes
    tick();
    re      = 2'b00;
    we      = 1'b1;
    wr_addr = 4'd3;
    wr_data = 16'h00AA;
    tick();
    we      = 1'b0;
    re      = 2'b01;
    rd_addr = {4'd0, 4'd3};
    @(negedge clk);
    chk("hold_load", 32'(p0(rd_data)), 32'h00AA);
    tick();
    re      = 2'b10;
    rd_addr = {4'd3, 4'd7};
    we      = 1'b1;
    wr_addr = 4'd3;
    wr_data = 16'h5555;
    @(negedge clk);
    chk("hold_keep", 32'(p0(rd_data)), 32'h00AA);
    chk("port1_byp", 32'(p1(rd_data)), 32'h5555);
    tick();
    we = 1'b0;
    @(negedge clk);
    chk("hold_keep2", 32'(p0(rd_data)), 32'h00AA);
    chk("port1_mem", 32'(p1(rd_data)), 32'h5555);

    // clear with a same-cycle write, writes dropped while busy
    tick();
    re      = 2'b00;
    we      = 1'b1;
    wr_addr = 4'd7;
    wr_data = 16'h0077;
    tick();
    wr_addr = 4'd8;
    wr_data = 16'h0088;
    clr     = 1'b1;
    @(negedge clk);
    chk("clr_idle", 32'(busy), 32'd0);
    tick();
    clr     = 1'b0;
    wr_addr = 4'd9;
    wr_data = 16'hFFFF;
    re      = 2'b10;
    rd_addr = {4'd7, 4'd0};
    #2;
    chk("busy_rd", 32'(p1(rd_data)), 32'h0);
    busy_len(n);
    chk("clr_sweep_len", n, 16);
    we      = 1'b0;
    re      = 2'b11;
    rd_addr = {4'd8, 4'd7};
    #2;
    chk("clr_rd78", rd_data, 32'h0);
    rd_addr = {4'd3, 4'd9};
    #2;
    chk("drop_wr9", 32'(p0(rd_data)), 32'h0);
    chk("clr_rd3", 32'(p1(rd_data)), 32'h0);

    // reset in the middle of a sweep
    tick();
    we      = 1'b1;
    wr_addr = 4'd5;
    wr_data = 16'hBEEF;
    re      = 2'b01;
    rd_addr = {4'd0, 4'd5};
    tick();
    we  = 1'b0;
    re  = 2'b00;
    clr = 1'b1;
    @(negedge clk);
    chk("hold_pre", 32'(p0(rd_data)), 32'hBEEF);
    tick();
    clr = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_busy", 32'(busy), 32'd1);
    chk("mid_rst_hold", 32'(p0(rd_data)), 32'h0);
    tick();
    rst_n = 1'b1;
    busy_len(n);
    chk("mid_sweep_len", n, 16);
    re = 2'b01;
    #2;
    chk("mid_rd5", 32'(p0(rd_data)), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
